fir_ss_source: RTL
==================

Name: fir_ss_source

Overview:
- AXI-Stream transmitter that drives the FIR engine's stream-in (ss_*) port.
- The host or testbench pushes samples into a small internal FIFO.
- On start, the block emits exactly cfg_len beats on ss_*, asserts ss_tlast on the final beat, then pulses done.
- Sits between the host-side sample writer and the FIR datapath's LOAD handshake.

Parameters:
- DATA_W, 32, width of samples and ss_tdata.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- LEN_W, 10, width of the frame-length counter.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- axis_rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a frame.
- cfg_len  in  LEN_W  beats per frame; sampled on an accepted start.
- busy  out  1  high from accepted start until the done pulse completes.
- done  out  1  one-cycle pulse after the last beat is accepted.
- wr_valid  in  1  host push request.
- wr_data  in  DATA_W  host sample.
- wr_ready  out  1  FIFO not full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ss_tvalid  out  1  stream valid.
- ss_tdata  out  DATA_W  stream data (FIFO head).
- ss_tlast  out  1  final beat of the frame.
- ss_tready  in  1  FIR engine ready.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and level go to 0; state goes to S_IDLE.
  - busy, done, ss_tvalid, ss_tlast go to 0; ss_tdata goes to 0.
  - wr_ready is 1 on the first cycle after reset.
  - Reset mid-frame discards the FIFO contents and the beat count. No done is produced.
- FIFO push:
  - Push occurs when wr_valid && wr_ready.
  - Pushes are accepted in every state.
  - wr_ready = !full, combinational from registered level.
  - When full there is no write-through, even if a pop happens in the same cycle.
- FIFO pop:
  - Pop occurs only when ss_tvalid && ss_tready.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: a word pushed in cycle N is visible on ss_tdata/ss_tvalid in cycle N+1, provided the FIFO was empty and the state is S_STREAM.
- ss_tdata is the FIFO head.
  - It stays stable while ss_tvalid && !ss_tready, since the head moves only on pop.
  - ss_tvalid never drops without a handshake.
- State machine, 2-bit encoding:
  - S_IDLE:
    - start && cfg_len != 0: latch len_r = cfg_len, clear beat_cnt, go to S_STREAM; busy = 1 next cycle.
    - start && cfg_len == 0: go directly to S_DONE (zero-length frame, no beats).
    - ss_tvalid = 0 in this state.
  - S_STREAM:
    - ss_tvalid = !empty.
    - ss_tlast = ss_tvalid && (beat_cnt == len_r - 1).
    - Each handshake increments beat_cnt.
    - A handshake with ss_tlast goes to S_DONE.
  - S_DONE: done = 1 and busy = 1 for exactly one cycle, then S_IDLE with busy = 0.
- start while busy is ignored. cfg_len changes after acceptance have no effect.
- Samples remaining in the FIFO beyond len_r stay queued for the next frame.
- An empty FIFO mid-frame deasserts ss_tvalid; streaming resumes on the next push.
- beat_cnt is LEN_W bits wide. The maximum frame is 2^LEN_W - 1 beats, with no wrap.

Decomposition:
- Package fir_axis_pkg holds:
  - state localparams S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2;
  - default DATA_W.
- One sub-module, sync_fifo (DATA_W, DEPTH):
  - push/pop, full/empty, level;
  - combinational head read from a register array.
- The FSM, beat counter and tlast logic stay in fir_ss_source.

Test Plan:
- Basic frame: pre-load 4 words (0x11, 0x22, 0x33, 0x44), cfg_len = 4, start, ss_tready = 1 → 4 consecutive beats in that order; ss_tlast only on 0x44; done pulses 1 cycle later; busy drops the cycle after that; level = 0.
- Backpressure: cfg_len = 3, ss_tready toggles 1,0,0,1,... → ss_tdata/ss_tvalid held stable while ready = 0; exactly 3 handshakes; ss_tlast on the 3rd; no dropped or duplicated data.
- Full/underflow: DEPTH = 8, push 9 words with start idle → wr_ready = 0 after the 8th; 9th not accepted; level = 8. Then cfg_len = 10 with the 9th and 10th words pushed later → ss_tvalid drops after 8 beats; resumes; tlast on beat 10.
- Leftover and zero length:
  - Push 5 words, cfg_len = 2 → 2 beats, done, level = 3.
  - Next start with cfg_len = 3 streams words 3 to 5.
  - start with cfg_len = 0 → done pulses; no ss_tvalid.
- Simultaneous push and pop at level = 4 during streaming → level stays 4. start during busy → ignored; beat count unchanged.
- Reset mid-frame after 2 of 5 beats → all outputs 0 immediately (async); level = 0; no done. A following frame with cfg_len = 1 works normally.

Source files
------------

// File: rtl/fir_axis_pkg.sv
// Shared definitions for the FIR stream-side blocks: FSM encodings and default widths.
package fir_axis_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_LEN_W  = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; pushes are refused when full,
// even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level_q
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_d;
  logic              do_push, do_pop;

  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);
  assign head_c  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && !full_c;
    do_pop   = pop && !empty_c;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/fir_ss_source.sv
// AXI-Stream source feeding the FIR engine: buffers host samples and emits
// cfg_len beats per started frame, flagging the last beat and pulsing done.
module fir_ss_source
  import fir_axis_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = AXIS_LEN_W
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       cfg_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ss_tvalid,
  output logic [DATA_W-1:0]      ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             full_c, empty_c, pop_c;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (axis_clk),
    .rst_n   (axis_rst_n),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (pop_c),
    .head_c  (ss_tdata),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level_q (level)
  );

  // Stream-side outputs are decoded from registered state and FIFO occupancy only.
  assign wr_ready  = !full_c;
  assign ss_tvalid = (state_q == S_STREAM) && !empty_c;
  assign ss_tlast  = ss_tvalid && (beat_q == len_q - LEN_W'(1));
  assign pop_c     = ss_tvalid && ss_tready;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            beat_d  = '0;
            state_d = S_STREAM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_STREAM: begin
        if (pop_c) begin
          beat_d = beat_q + LEN_W'(1);
          if (ss_tlast) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

endmodule
